// File: rtl/seq_gate_pkg.sv
// Shared types and constants for the seq_gate_array channel sequencer.
package seq_gate_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

   // Scan chain order, SI side first, SO side last
   localparam int SCAN_IDX_STATE = 0;
   localparam int SCAN_IDX_CNT   = 1;
   localparam int SCAN_IDX_IVL   = 2;
   localparam int SCAN_IDX_MD    = 3;
   localparam int SCAN_IDX_PTR   = 4;
   localparam int SCAN_IDX_PULSE = 5;
   localparam int SCAN_IDX_DONE  = 6;

   function automatic int scan_len(input int cw, input int nch, input int pw);
      return 3 + 2 * cw + pw + nch;
   endfunction

endpackage

// File: rtl/seq_gate_array_counter.sv
// Loadable CW-bit down-counter; holds at zero and flags terminal count.
module seq_gate_counter #(
   parameter int CW = 4
) (
   input  logic          CK,
   input  logic          RST,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          en,
   output logic [CW-1:0] cnt,
   output logic          tc
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge CK) begin
      if (RST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;
   assign tc  = (cnt_q == '0);

endmodule

// File: rtl/seq_gate_array.sv
// Round-robin gated pulse sequencer with one-shot/periodic modes.
// Optional scan chain enabled by defining SEQ_GATE_SCAN_CHAIN_EN.
module seq_gate_array
   import seq_gate_pkg::*;
#(
   parameter  int NCH = 8,
   parameter  int CW  = 4,
   localparam int PW  = $clog2(NCH)
) (
   input  logic           CK,
   input  logic           RST,
   input  logic           START,
   input  logic           STOP,
   input  logic           MODE,
   input  logic [CW-1:0]  LOAD_VAL,
   input  logic [NCH-1:0] CH_EN,
`ifdef SEQ_GATE_SCAN_CHAIN_EN
   input  logic           SE,
   input  logic           SI,
   output logic           SO,
`endif
   output logic [NCH-1:0] PULSE,
   output logic [PW-1:0]  CUR_CH,
   output logic           BUSY,
   output logic           DONE
);

   state_e         state_q, state_d;
   logic [CW-1:0]  ivl_q, ivl_d;
   logic           md_q, md_d;
   logic [PW-1:0]  ptr_q, ptr_d;
   logic [NCH-1:0] pulse_q, pulse_d;
   logic           done_q, done_d;

   logic           ld;
   logic [CW-1:0]  ld_val;
   logic           cen;
   logic [CW-1:0]  cnt_w;
   logic           tc_w;

`ifdef SEQ_GATE_SCAN_CHAIN_EN
   localparam int SL = scan_len(CW, NCH, PW);
   logic [SL-1:0] chain_q;
   logic [SL-1:0] sh_d;
   logic          st_s;

   assign chain_q = {state_q, cnt_w, ivl_q, md_q, ptr_q, pulse_q, done_q};
   assign SO      = done_q;
`endif

   seq_gate_counter #(
      .CW(CW)
   ) u_cnt (
      .CK      (CK),
      .RST     (RST),
      .load    (ld),
      .load_val(ld_val),
      .en      (cen),
      .cnt     (cnt_w),
      .tc      (tc_w)
   );

   always_comb begin
      state_d = state_q;
      ivl_d   = ivl_q;
      md_d    = md_q;
      ptr_d   = ptr_q;
      pulse_d = '0;
      done_d  = 1'b0;
      ld      = 1'b0;
      ld_val  = ivl_q;
      cen     = 1'b0;
`ifdef SEQ_GATE_SCAN_CHAIN_EN
      sh_d    = '0;
      st_s    = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (START && !STOP) begin
               ivl_d   = LOAD_VAL;
               md_d    = MODE;
               ld      = 1'b1;
               ld_val  = LOAD_VAL;
               ptr_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (STOP) begin
               state_d = IDLE;
               ptr_d   = '0;
            end else if (!tc_w) begin
               cen = 1'b1;
            end else begin
               pulse_d = CH_EN[ptr_q] ? (NCH'(1) << ptr_q) : '0;
               ld      = 1'b1;
               if (ptr_q == PW'(NCH - 1)) begin
                  ptr_d = '0;
                  if (md_q == MODE_ONESHOT) begin
                     done_d  = 1'b1;
                     state_d = IDLE;
                  end
               end else begin
                  ptr_d = ptr_q + PW'(1);
               end
            end
         end
      endcase
`ifdef SEQ_GATE_SCAN_CHAIN_EN
      // Shift overrides every functional update, counter included
      if (SE) begin
         sh_d = {SI, chain_q[SL-1:1]};
         {st_s, ld_val, ivl_d, md_d, ptr_d, pulse_d, done_d} = sh_d;
         state_d = state_e'(st_s);
         ld      = 1'b1;
         cen     = 1'b0;
      end
`endif
   end

   always_ff @(posedge CK) begin
      if (RST) begin
         state_q <= IDLE;
         ivl_q   <= '0;
         md_q    <= 1'b0;
         ptr_q   <= '0;
         pulse_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ivl_q   <= ivl_d;
         md_q    <= md_d;
         ptr_q   <= ptr_d;
         pulse_q <= pulse_d;
         done_q  <= done_d;
      end
   end

   assign PULSE  = pulse_q;
   assign CUR_CH = ptr_q;
   assign BUSY   = (state_q == RUN);
   assign DONE   = done_q;

endmodule
